mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Main control unit for the multicycle MIPS datapath.
- A Moore state machine that sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction.
- Drives every datapath select and enable, including MemtoReg, which steers the register-file write-data mux between ALUOut and the memory data register.
- Stalls on a memory-ready handshake and flags illegal opcodes.

Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word opcode
- OP_SW, 6'h2B, store word opcode
- OP_BEQ, 6'h04, branch-equal opcode
- OP_J, 6'h02, jump opcode
- OP_ADDI, 6'h08, add-immediate opcode

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Opcode  input  6  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero
- IorD  output  1  memory address select (0 = PC, 1 = ALUOut)
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  write-data select (1 = memory data register, 0 = ALUOut)
- RegDst  output  1  destination select (1 = rd, 0 = rt)
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A select (0 = PC, 1 = register A)
- ALUSrcB  output  2  ALU B select (00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2)
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  one-cycle pulse on an unknown opcode
- state_dbg  output  4  current state encoding

Behaviour:
- Reset: the asynchronous assert forces state IDLE immediately, mid-instruction included. In IDLE every output is 0 and state_dbg = 0. The first clock after deassert moves to FETCH.
- All outputs are Moore: a pure function of the registered state, except illegal_op (see DECODE).
- Outputs not listed for a state are 0.
- States, encodings, outputs and transitions:
  - IDLE(0): all outputs 0 -> FETCH.
  - FETCH(1): MemRead, IRWrite, ALUSrcB=01, ALUOp=00, PCWrite, PCSource=00. Holds while mem_ready=0. While waiting, IRWrite and PCWrite are forced low, so the PC advances exactly once, on the ready cycle. On mem_ready=1 -> DECODE.
  - DECODE(2): ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Opcode:
    - LW/SW -> MEMADR
    - RTYPE -> EXECUTE
    - BEQ -> BRANCH
    - J -> JUMP
    - ADDI -> ADDIEX
    - otherwise -> FETCH, with illegal_op=1 for this cycle (combinational on Opcode while in DECODE).
  - MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMRD; SW -> MEMWR.
  - MEMRD(4): MemRead, IorD. Holds until mem_ready -> MEMWB.
  - MEMWB(5): RegWrite, MemtoReg=1, RegDst=0 -> FETCH.
  - MEMWR(6): MemWrite, IorD. Holds until mem_ready -> FETCH. MemWrite stays asserted across the whole wait.
  - EXECUTE(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB(8): RegWrite, RegDst=1, MemtoReg=0 -> FETCH.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01 -> FETCH.
  - JUMP(10): PCWrite, PCSource=10 -> FETCH.
  - ADDIEX(11): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB(12): RegWrite, RegDst=0, MemtoReg=0 -> FETCH.
- Encodings 13-15 are unreachable. If entered, the FSM goes to FETCH on the next clock with all outputs 0.
- Invariants:
  - RegWrite and MemWrite are never both high.
  - MemtoReg=1 only in MEMWB.
  - Opcode is sampled only in DECODE and MEMADR. The IR must hold it, since IRWrite is low outside FETCH.
- Cycle counts with mem_ready tied 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings (S_IDLE..S_ADDIWB)
  - opcode constants
  - ALUOp, ALUSrcB and PCSource codes, which the ALU control and PC mux also use.
- One sub-module, mc_control_outdec: a combinational state -> control-word decoder.
- The top keeps the state register and next-state logic.

Test Plan:
- rst_n low, then high, with Opcode=LW and mem_ready=1 -> states 0,1,2,3,4,5,1. MemtoReg=1 and RegWrite=1 only in cycle 5; all outputs 0 during reset.
- R-type (Opcode=0x00) -> states 1,2,7,8,1. ALUOp=10 in EXECUTE; RegDst=1, RegWrite=1 and MemtoReg=0 in ALUWB.
- SW with mem_ready low for 3 cycles in MEMWR -> MemWrite held for 4 cycles, IorD=1 throughout, then FETCH. RegWrite stays 0 throughout.
- FETCH with mem_ready low for 2 cycles -> PCWrite and IRWrite low while waiting, high exactly 1 cycle on ready.
- Opcode=0x3F in DECODE -> illegal_op pulses 1 cycle and the next state is FETCH. BEQ -> PCWriteCond=1 with PCSource=01 for 1 cycle. J -> PCWrite=1 with PCSource=10.
- rst_n asserted in MEMRD mid-stall -> state_dbg reads 0 and all outputs read 0 before the next clock edge. After release: IDLE, then FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// and the ALU/PC select codes also used by the ALU control and the PC mux.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDIEX  = 4'd11,
        S_ADDIWB  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctl_word_t;

endpackage

// File: rtl/mc_control_outdec.sv
// State -> datapath control word. Purely combinational; the only non-state
// input is mem_ready, which holds PC/IR loads off while a fetch is stalled.
module mc_control_outdec
    import mc_pkg::*;
(
    input  state_t    state,
    input  logic      mem_ready,
    output ctl_word_t ctl
);

    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALUOP_ADD;
                ctl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctl.alu_src_b = SRCB_IMM_SH2;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRCB_B;
                ctl.alu_op        = ALUOP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                ctl.reg_write = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: state register and next-state logic; the
// control word itself comes from mc_control_outdec.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | held in / just out of reset, all outputs 0
// FETCH   | read instruction, PC+4 (waits on mem_ready)
// DECODE  | branch target into ALUOut, dispatch on opcode
// MEMADR  | effective address for LW/SW
// MEMRD   | load data read (waits on mem_ready)
// MEMWB   | load data to rt
// MEMWR   | store write (waits on mem_ready)
// EXECUTE | R-type ALU operation
// ALUWB   | R-type result to rd
// BRANCH  | BEQ compare and conditional PC load
// JUMP    | jump target into PC
// ADDIEX  | ADDI ALU operation
// ADDIWB  | ADDI result to rt
module mc_control_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t    state, state_nxt;
    ctl_word_t ctl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        illegal_op = 1'b0;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXECUTE;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    default: begin
                        state_nxt  = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            // Only LW/SW reach MEMADR, so anything not SW is treated as a load.
            S_MEMADR:  state_nxt = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_nxt = S_FETCH;
            S_EXECUTE: state_nxt = S_ALUWB;
            S_ADDIEX:  state_nxt = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: state_nxt = S_FETCH;
            default:   state_nxt = S_FETCH;
        endcase
    end

    mc_control_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .ctl       (ctl)
    );

    assign PCWrite     = ctl.pc_write;
    assign PCWriteCond = ctl.pc_write_cond;
    assign IorD        = ctl.i_or_d;
    assign MemRead     = ctl.mem_read;
    assign MemWrite    = ctl.mem_write;
    assign IRWrite     = ctl.ir_write;
    assign MemtoReg    = ctl.mem_to_reg;
    assign RegDst      = ctl.reg_dst;
    assign RegWrite    = ctl.reg_write;
    assign ALUSrcA     = ctl.alu_src_a;
    assign ALUSrcB     = ctl.alu_src_b;
    assign ALUOp       = ctl.alu_op;
    assign PCSource    = ctl.pc_source;
    assign state_dbg   = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: the driver expands each instruction into
// its per-cycle step list and queues the expected outputs; a negedge monitor checks.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_dbg;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aop, psrc;
        logic ill;
    } obs_t;

    localparam int IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4,
                   MEMWB = 5, MEMWR = 6, EXEC = 7, ALUWB = 8, BRANCH = 9,
                   JUMP = 10, ADDIEX = 11, ADDIWB = 12;

    obs_t act;
    assign act = {state_dbg, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // What the datapath should see in a given step, written from the control table.
    function automatic obs_t step_out(int st, logic rdy, logic ill);
        obs_t e = '0;
        e.st = 4'(st);
        case (st)
            FETCH:  begin e.mrd = 1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            DECODE: begin e.srcb = 2'b11; e.ill = ill; end
            MEMADR: begin e.srca = 1; e.srcb = 2'b10; end
            MEMRD:  begin e.mrd = 1; e.iord = 1; end
            MEMWB:  begin e.rw = 1; e.m2r = 1; end
            MEMWR:  begin e.mwr = 1; e.iord = 1; end
            EXEC:   begin e.srca = 1; e.aop = 2'b10; end
            ALUWB:  begin e.rw = 1; e.rdst = 1; end
            BRANCH: begin e.srca = 1; e.aop = 2'b01; e.pcwc = 1; e.psrc = 2'b01; end
            JUMP:   begin e.pcw = 1; e.psrc = 2'b10; end
            ADDIEX: begin e.srca = 1; e.srcb = 2'b10; end
            ADDIWB: begin e.rw = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    endfunction

    task automatic push_cycle(obs_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One step lasting stalls+1 cycles; memory steps see mem_ready only on the last.
    task automatic step(int st, int stalls, logic ill);
        bit waits = (st == FETCH || st == MEMRD || st == MEMWR);
        for (int i = 0; i <= stalls; i++) begin
            mem_ready = waits ? (i == stalls) : 1'($urandom_range(1));
            push_cycle(step_out(st, mem_ready, ill));
        end
    endtask

    task automatic run_instr(logic [5:0] op, int fetch_stall, int mem_stall);
        Opcode = op;
        step(FETCH, fetch_stall, 1'b0);
        if (!is_legal(op)) begin
            step(DECODE, 0, 1'b1);
            return;
        end
        step(DECODE, 0, 1'b0);
        case (op)
            6'h23: begin step(MEMADR, 0, 0); step(MEMRD, mem_stall, 0); step(MEMWB, 0, 0); end
            6'h2B: begin step(MEMADR, 0, 0); step(MEMWR, mem_stall, 0); end
            6'h00: begin step(EXEC, 0, 0); step(ALUWB, 0, 0); end
            6'h04: step(BRANCH, 0, 0);
            6'h02: step(JUMP, 0, 0);
            default: begin step(ADDIEX, 0, 0); step(ADDIWB, 0, 0); end
        endcase
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL outputs cycle %0d: got %h wanted %h (state got %0d wanted %0d)",
                         cyc, act, e, act.st, e.st);
            end
            total++;
            if (RegWrite === 1'b1 && MemWrite === 1'b1) begin
                bad++;
                $display("FAIL rw_mw_exclusive cycle %0d: got RegWrite=1 MemWrite=1 wanted not both", cyc);
            end
        end
    end

    logic [5:0] ops[10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h01, 6'h10, 6'h2A};

    initial begin
        rst_n = 1'b0;
        Opcode = 6'h23;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) push_cycle(step_out(IDLE, 0, 0));
        rst_n = 1'b1;
        push_cycle(step_out(IDLE, 0, 0));

        run_instr(6'h23, 0, 0);
        run_instr(6'h00, 0, 0);
        run_instr(6'h2B, 0, 3);
        run_instr(6'h08, 2, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h04, 0, 0);
        run_instr(6'h02, 0, 0);

        for (int n = 0; n < 80; n++)
            run_instr(ops[$urandom_range(9)], $urandom_range(3), $urandom_range(4));

        // Reset asserted while MEMRD is stalled.
        Opcode = 6'h23;
        step(FETCH, 0, 0);
        step(DECODE, 0, 0);
        step(MEMADR, 0, 0);
        mem_ready = 1'b0;
        push_cycle(step_out(MEMRD, 0, 0));
        mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (act !== '0) begin
            bad++;
            $display("FAIL async_reset: got %h wanted 0", act);
        end
        push_cycle(step_out(IDLE, 0, 0));
        push_cycle(step_out(IDLE, 0, 0));
        rst_n = 1'b1;
        push_cycle(step_out(IDLE, 0, 0));
        run_instr(6'h00, 1, 0);
        run_instr(6'h23, 0, 2);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left wanted 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
